// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling engine.
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        LAT_I,
        RD_J,
        LAT_J,
        WR_I,
        WR_J,
        FINISH
    } rc4_state_t;

    localparam int S_DEPTH           = 256;
    localparam int S_ADDR_WIDTH      = 8;
    localparam int KEY_BYTES_DEFAULT = 3;

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Port bundle between the KSA engine and the 256x8 single-port S-array RAM.
interface rc4_ksa_engine_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;

    modport master (
        output mem_address,
        output mem_data,
        output mem_wren,
        input  mem_q
    );

    modport slave (
        input  mem_address,
        input  mem_data,
        input  mem_wren,
        output mem_q
    );

endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling controller: fills S[k]=k, then performs the 256 KSA swaps
// through a single-port RAM with 1-cycle registered read latency.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES  = KEY_BYTES_DEFAULT,
    parameter int ADDR_WIDTH = S_ADDR_WIDTH,
    parameter int DATA_WIDTH = S_ADDR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] key,
    rc4_ksa_engine_if.master       mem,
    output logic                   busy,
    output logic                   done
);

    localparam int            KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

    rc4_state_t             state;
    logic [ADDR_WIDTH-1:0]  i;
    logic [ADDR_WIDTH-1:0]  j;
    logic [KW-1:0]          k;
    logic [DATA_WIDTH-1:0]  si;
    logic [DATA_WIDTH-1:0]  sj;
    logic [KEY_BYTES*8-1:0] key_r;
    logic [7:0]             keybyte;

    // Byte 0 of the key sits in the most significant byte lane.
    always_comb begin
        keybyte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k == KW'(b)) begin
                keybyte = key_r[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            key_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_r <= key;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= INIT;
                    end
                end
                INIT: begin
                    i <= i + 1'b1;
                    if (i == '1) begin
                        j     <= '0;
                        state <= RD_I;
                    end
                end
                RD_I:  state <= LAT_I;
                LAT_I: begin
                    si    <= mem.mem_q;
                    j     <= j + mem.mem_q + keybyte;
                    state <= RD_J;
                end
                RD_J:  state <= LAT_J;
                LAT_J: begin
                    sj    <= mem.mem_q;
                    state <= WR_I;
                end
                WR_I:  state <= WR_J;
                WR_J: begin
                    i <= i + 1'b1;
                    k <= (k == K_LAST) ? '0 : k + 1'b1;
                    if (i == '1) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        state <= RD_I;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM bus is a pure decode of state and registers; mem_q never reaches it.
    always_comb begin
        mem.mem_address = '0;
        mem.mem_data    = '0;
        mem.mem_wren    = 1'b0;
        case (state)
            INIT: begin
                mem.mem_address = i;
                mem.mem_data    = i;
                mem.mem_wren    = 1'b1;
            end
            RD_I, LAT_I: mem.mem_address = i;
            RD_J, LAT_J: mem.mem_address = j;
            WR_I: begin
                mem.mem_address = i;
                mem.mem_data    = sj;
                mem.mem_wren    = 1'b1;
            end
            WR_J: begin
                mem.mem_address = j;
                mem.mem_data    = si;
                mem.mem_wren    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Self-checking bench for rc4_ksa_engine with an S-array RAM model and a
// software RC4 key-schedule reference.
module tb_rc4_ksa_engine;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [23:0] key;
    logic        busy;
    logic        done;

    rc4_ksa_engine_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) mem_bus ();

    rc4_ksa_engine #(.KEY_BYTES(3), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .key     (key),
        .mem     (mem_bus),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single-port RAM, registered read, old data on read-during-write.
    logic [7:0] ram [256];
    always @(posedge clock) begin
        if (mem_bus.mem_wren) ram[mem_bus.mem_address] <= mem_bus.mem_data;
        mem_bus.mem_q <= ram[mem_bus.mem_address];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_s [256];

    task automatic ksa_ref(input logic [23:0] kv);
        int         jj;
        logic [7:0] t;
        logic [7:0] kb [3];
        kb[0] = kv[23:16];
        kb[1] = kv[15:8];
        kb[2] = kv[7:0];
        for (int x = 0; x < 256; x++) exp_s[x] = 8'(x);
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            jj = (jj + int'(exp_s[ii]) + int'(kb[ii % 3])) % 256;
            t          = exp_s[ii];
            exp_s[ii]  = exp_s[jj];
            exp_s[jj]  = t;
        end
    endtask

    int         done_cnt, done_cyc, busy_fall, init_err;
    bit         busy_at_done, init_ok;
    logic [7:0] snap [3][4];

    task automatic run_ksa(input logic [23:0] kv, input int abort_at, input int poke_at);
        int c;
        done_cnt = 0; done_cyc = 0; busy_fall = 0; init_err = -1;
        busy_at_done = 1'b0; init_ok = 1'b1;
        @(negedge clock);
        key   = kv;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 1;
        while (c < 4000) begin
            if (done) begin
                done_cnt++;
                done_cyc     = c;
                busy_at_done = busy;
            end
            if (!busy) break;
            if (c <= 256 && !(mem_bus.mem_wren && mem_bus.mem_address == 8'(c-1)
                              && mem_bus.mem_data == 8'(c-1))) init_ok = 1'b0;
            if (c == 257) begin
                init_err = 0;
                for (int x = 0; x < 256; x++) if (ram[x] !== 8'(x)) init_err++;
            end
            if (c >= 263 && c <= 275 && (c - 263) % 6 == 0)
                for (int x = 0; x < 4; x++) snap[(c-263)/6][x] = ram[x];
            if (c == 10) key = $urandom;
            if (c == poke_at) begin
                start = 1'b1;
                key   = $urandom;
            end
            if (c == poke_at + 1) start = 1'b0;
            if (c == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk("abort_wren", 32'(mem_bus.mem_wren), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(done), 0);
                break;
            end
            @(negedge clock);
            c++;
        end
        start     = 1'b0;
        busy_fall = c;
    endtask

    task automatic post_run(input logic [23:0] kv, input string tag);
        int  mism, dups;
        bit  seen [256];
        ksa_ref(kv);
        mism = 0;
        dups = 0;
        for (int x = 0; x < 256; x++) seen[x] = 1'b0;
        for (int x = 0; x < 256; x++) begin
            if (ram[x] !== exp_s[x]) mism++;
            if (seen[ram[x]]) dups++;
            seen[ram[x]] = 1'b1;
        end
        chk({tag, "_final_s_mismatches"}, 32'(mism), 0);
        chk({tag, "_perm_dups"}, 32'(dups), 0);
        chk({tag, "_done_count"}, 32'(done_cnt), 1);
        chk({tag, "_done_cycle"}, 32'(done_cyc), 1793);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 1);
        chk({tag, "_busy_fall"}, 32'(busy_fall), 1794);
        chk({tag, "_done_after"}, 32'(done), 0);
    endtask

    initial begin
        logic [23:0] rk;
        reset_n = 1'b0;
        start   = 1'b1;
        key     = 24'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_wren", 32'(mem_bus.mem_wren), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        start   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("idle_wren", 32'(mem_bus.mem_wren), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_addr", 32'(mem_bus.mem_address), 0);
        end

        run_ksa(24'h010203, 0, 0);
        chk("init_bus", 32'(init_ok), 1);
        chk("init_ram_errors", 32'(init_err), 0);
        chk("k1_it0_s0", 32'(snap[0][0]), 1);
        chk("k1_it0_s1", 32'(snap[0][1]), 0);
        chk("k1_it1_s1", 32'(snap[1][1]), 3);
        chk("k1_it1_s3", 32'(snap[1][3]), 0);
        post_run(24'h010203, "k010203");

        run_ksa(24'h000000, 0, 0);
        chk("k0_it1_s0", 32'(snap[1][0]), 0);
        chk("k0_it1_s1", 32'(snap[1][1]), 1);
        chk("k0_it2_s2", 32'(snap[2][2]), 3);
        chk("k0_it2_s3", 32'(snap[2][3]), 2);
        post_run(24'h000000, "k000000");

        run_ksa(24'h000249, 0, 0);
        post_run(24'h000249, "k000249");

        run_ksa(24'h010203, 900, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_abort_busy", 32'(busy), 0);
        run_ksa(24'h010203, 0, int'($urandom_range(1700, 300)));
        post_run(24'h010203, "restart");

        for (int r = 0; r < 3; r++) begin
            rk = $urandom;
            run_ksa(rk, 0, int'($urandom_range(1700, 300)));
            post_run(rk, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_engine.md
Name: rc4_ksa_engine

Overview:
- Upstream controller for the 256x8 single-port S-array RAM (registered read, 1-cycle latency, no write-first bypass).
- Fills S[k]=k, then runs the RC4 key-scheduling pass: for i=0..255, j=j+S[i]+key[i mod KEY_BYTES] (mod 256), swap S[i],S[j].
- Drives the RAM's address/data/wren and consumes its q.
- Started by a one-cycle start handshake; reports busy and a done pulse to the top-level controller.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes cycled through during scheduling.
- ADDR_WIDTH, 8, S-array address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, S-array entry width; must equal ADDR_WIDTH.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- key  in  KEY_BYTES*8  secret key; byte 0 = key[KEY_BYTES*8-1 -: 8] (MSB first); latched at start.
- mem_address  out  ADDR_WIDTH  S-RAM address.
- mem_data  out  DATA_WIDTH  S-RAM write data.
- mem_wren  out  1  S-RAM write enable.
- mem_q  in  DATA_WIDTH  S-RAM read data, valid the cycle after its address was presented.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the S-array is final.

Behaviour:
- Reset (async assert, sync release) gives: state IDLE; i, j, k, si, sj, key_r all 0; mem_address=0, mem_data=0, mem_wren=0, busy=0, done=0.
- Outputs are decoded from state and internal registers only. There is no combinational path from mem_q to any output.
- State sequence:
  - IDLE: wren=0. If start=1, latch key, clear i, j and k, and go to INIT. Otherwise stay in IDLE.
  - INIT: addr=i, data=i, wren=1, then i<=i+1. When i==255, i wraps to 0, j<=0 and the next state is RD_I. Occupies 256 cycles.
  - RD_I: addr=i, wren=0.
  - LAT_I: mem_q=S[i]. Set si<=mem_q and j<=j+mem_q+keybyte[k] (8-bit wrap, carries discarded).
  - RD_J: addr=j (the updated value), wren=0.
  - LAT_J: sj<=mem_q.
  - WR_I: addr=i, data=sj, wren=1.
  - WR_J: addr=j, data=si, wren=1. Then i<=i+1, and k<=(k==KEY_BYTES-1)?0:k+1. If i==255 go to FINISH, otherwise go to RD_I.
  - FINISH: done=1 for exactly one cycle, wren=0, then IDLE.
- Latency: 6 cycles per swap iteration and 256+1536=1792 busy cycles. done is high in the 1793rd cycle after busy rises.
- k is an explicit modulo counter. There is no divider and no modulo operator.
- i==j case: WR_I writes S[j]=S[i] back to i, then WR_J writes si to the same address. The entry is unchanged, which is correct.
- start while busy is ignored. key changes while busy are ignored (key_r is used).
- start held high across FINISH re-triggers on the first IDLE cycle. There is no dead time.
- Reset mid-operation aborts immediately, and wren drops asynchronously. RAM contents are then partial and undefined; the caller must restart.
- Read-during-write is never needed: no state reads an address in the cycle it is written.

Decomposition:
- Shared package rc4_pkg contains:
  - the state enum (IDLE, INIT, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, FINISH);
  - S_DEPTH=256;
  - S_ADDR_WIDTH=8;
  - KEY_BYTES_DEFAULT=3.
- Sub-modules: none required. The key-byte mux plus modulo counter may optionally be split out as rc4_key_byte_sel (inputs key_r, k; output keybyte). The FSM and datapath stay in one module.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles with start=1, then release with start=0 → wren=0, busy=0, done=0, address=0 for 10 cycles.
- Init phase: start with key 24'h010203 → the first 256 busy cycles write addr k with data k, wren=1 every cycle; RAM model holds S[k]=k.
- First swaps with key 24'h010203:
  - after the i=0 iteration, S[0]=1 and S[1]=0;
  - after i=1 (j=1+0+2=3), S[1]=3 and S[3]=0.
- Self-swap with key 24'h000000:
  - i=0 gives j=0, i=1 gives j=1 (both self-swaps), so S[0]=0 and S[1]=1;
  - i=2 gives j=3, so S[2]=3 and S[3]=2.
- Full run plus timing:
  - with key 24'h000249, done pulses exactly once, 1793 cycles after busy rises, and busy falls in the same cycle that done falls;
  - the final S must be a permutation of 0..255 and match a software RC4 KSA model byte for byte.
- Abort and restart: pull reset_n low at cycle 900 → wren=0 and busy=0 immediately. Then restart with key 24'h010203 → the result matches the uninterrupted run, and a start pulse mid-run is ignored (done count stays 1).
